// File: rtl/rv_arbiter.sv
// ============================================================================
// Module      : rv_arbiter
// Description : 4-requester ready/valid arbiter feeding one output holding
//               register. Round-robin by default; define RV_ARB_FIXED_PRI_EN
//               for fixed priority (requester 0 highest).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         in_valid,
  output logic [3:0]         in_ready,
  input  logic [4*WIDTH-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         out_id
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic [WIDTH-1:0] r_data;
  logic [1:0]       r_id;
  logic [1:0]       w_base;
  logic [3:0]       w_rot;
  logic [1:0]       w_off;
  logic [1:0]       w_gnt;
  logic             w_any;
  logic             w_can_accept;
  logic             w_xfer;
  logic [WIDTH-1:0] w_gnt_data;

`ifdef RV_ARB_FIXED_PRI_EN
  assign w_base = 2'd0;
`else
  logic [1:0] r_ptr;

  // Pointer moves only on a transfer, to the requester after the winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= 2'd0;
    end else if (w_xfer) begin
      r_ptr <= w_gnt + 2'd1;
    end
  end

  assign w_base = r_ptr;
`endif

  // Rotate the request vector so the search always starts at bit 0.
  always_comb begin
    w_rot = '0;
    for (int i = 0; i < 4; i++) begin
      w_rot[i] = in_valid[w_base + 2'(i)];
    end
  end

  always_comb begin
    w_off = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (w_rot[i]) w_off = 2'(i);
    end
  end

  assign w_gnt        = w_base + w_off;
  assign w_any        = |in_valid;
  assign w_can_accept = (r_state == ST_EMPTY) || out_ready;
  assign w_xfer       = |(in_valid & in_ready);

  always_comb begin
    w_gnt_data = '0;
    for (int i = 0; i < 4; i++) begin
      if (w_gnt == 2'(i)) w_gnt_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
      r_data  <= '0;
      r_id    <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_xfer) begin
        r_data <= w_gnt_data;
        r_id   <= w_gnt;
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (w_xfer) begin
      w_state_nxt = ST_FULL;
    end else if ((r_state == ST_FULL) && out_ready) begin
      w_state_nxt = ST_EMPTY;
    end
  end

  // Output logic
  always_comb begin
    in_ready = 4'b0000;
    if (!rst && w_any && w_can_accept) begin
      in_ready = 4'b0001 << w_gnt;
    end
    out_valid = (r_state == ST_FULL);
    out_data  = r_data;
    out_id    = r_id;
  end

endmodule

`default_nettype wire

// File: tb/tb_rv_arbiter.sv
// ============================================================================
// Module      : tb_rv_arbiter
// Description : Table-driven self-checking bench for rv_arbiter, plus a
//               multi-cycle grant-count sequence.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv_arbiter;

  localparam int WIDTH = 8;

  logic               clk;
  logic               rst;
  logic [3:0]         in_valid;
  logic [3:0]         in_ready;
  logic [4*WIDTH-1:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [1:0]         out_id;

  int total;
  int bad;

  rv_arbiter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  iv;
    logic [31:0] data;
    logic        ordy;
    logic        chk;
    logic [3:0]  ir;
    logic        ov;
    logic [7:0]  od;
    logic [1:0]  id;
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] D  = 32'hA3A2A1A0;
  localparam logic [31:0] D2 = 32'hA355A1A0;

  task automatic add(input logic r, input logic [3:0] iv, input logic [31:0] d,
                     input logic ordy, input logic chk, input logic [3:0] ir,
                     input logic ov, input logic [7:0] od, input logic [1:0] id);
    vec_t v;
    v.rst = r; v.iv = iv; v.data = d; v.ordy = ordy; v.chk = chk;
    v.ir = ir; v.ov = ov; v.od = od; v.id = id;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d got=%h want=%h", name, idx, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  int cnt[4];

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1; in_valid = 4'b0; in_data = '0; out_ready = 1'b0;

`ifndef RV_ARB_FIXED_PRI_EN
    //   rst iv       data ordy chk ir       ov   od     id
    add(1, 4'b1111, D,  0, 0, 4'b0000, 0, 8'h00, 2'd0);
    add(1, 4'b1111, D,  0, 1, 4'b0000, 0, 8'h00, 2'd0);
    add(0, 4'b1111, D,  0, 1, 4'b0001, 0, 8'h00, 2'd0);
    add(0, 4'b1111, D,  1, 1, 4'b0010, 1, 8'hA0, 2'd0);
    add(0, 4'b1111, D,  1, 1, 4'b0100, 1, 8'hA1, 2'd1);
    add(0, 4'b1111, D,  1, 1, 4'b1000, 1, 8'hA2, 2'd2);
    add(0, 4'b1111, D,  1, 1, 4'b0001, 1, 8'hA3, 2'd3);
    add(0, 4'b0000, D,  1, 1, 4'b0000, 1, 8'hA0, 2'd0);
    add(0, 4'b0000, D,  1, 1, 4'b0000, 0, 8'hA0, 2'd0);
    add(0, 4'b1000, D,  0, 1, 4'b1000, 0, 8'hA0, 2'd0);
    add(0, 4'b1001, D,  1, 1, 4'b0001, 1, 8'hA3, 2'd3);
    add(0, 4'b0000, D,  1, 1, 4'b0000, 1, 8'hA0, 2'd0);
    add(0, 4'b0100, D2, 0, 1, 4'b0100, 0, 8'hA0, 2'd0);
    add(0, 4'b0010, D2, 0, 1, 4'b0000, 1, 8'h55, 2'd2);
    add(0, 4'b0010, D2, 0, 1, 4'b0000, 1, 8'h55, 2'd2);
    add(0, 4'b0010, D2, 0, 1, 4'b0000, 1, 8'h55, 2'd2);
    add(0, 4'b0010, D2, 1, 1, 4'b0010, 1, 8'h55, 2'd2);
    add(0, 4'b0000, D,  1, 1, 4'b0000, 1, 8'hA1, 2'd1);
    add(0, 4'b1111, D,  0, 1, 4'b0100, 0, 8'hA1, 2'd1);
    add(1, 4'b1111, D,  0, 1, 4'b0000, 1, 8'hA2, 2'd2);
    add(0, 4'b1111, D,  0, 1, 4'b0001, 0, 8'h00, 2'd0);
    add(0, 4'b0000, D,  0, 1, 4'b0000, 1, 8'hA0, 2'd0);
    add(0, 4'b0000, D,  1, 1, 4'b0000, 1, 8'hA0, 2'd0);
    add(0, 4'b0000, D,  1, 1, 4'b0000, 0, 8'hA0, 2'd0);
`else
    add(1, 4'b1111, D,  1, 0, 4'b0000, 0, 8'h00, 2'd0);
    add(0, 4'b1111, D,  1, 1, 4'b0001, 0, 8'h00, 2'd0);
    add(0, 4'b1111, D,  1, 1, 4'b0001, 1, 8'hA0, 2'd0);
    add(0, 4'b1111, D,  1, 1, 4'b0001, 1, 8'hA0, 2'd0);
    add(0, 4'b1111, D,  1, 1, 4'b0001, 1, 8'hA0, 2'd0);
    add(0, 4'b1010, D,  1, 1, 4'b0010, 1, 8'hA0, 2'd0);
    add(0, 4'b1000, D,  1, 1, 4'b1000, 1, 8'hA1, 2'd1);
    add(0, 4'b0000, D,  1, 1, 4'b0000, 1, 8'hA3, 2'd3);
    add(0, 4'b0000, D,  1, 1, 4'b0000, 0, 8'hA3, 2'd3);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      rst       = vecs[i].rst;
      in_valid  = vecs[i].iv;
      in_data   = vecs[i].data;
      out_ready = vecs[i].ordy;
      #1;
      check("in_ready", i, 32'(in_ready), 32'(vecs[i].ir));
      if (vecs[i].chk) begin
        check("out_valid", i, 32'(out_valid), 32'(vecs[i].ov));
        check("out_data",  i, 32'(out_data),  32'(vecs[i].od));
        check("out_id",    i, 32'(out_id),    32'(vecs[i].id));
      end
      @(posedge clk);
      #1;
    end

    // Continuous contention: count grants per requester over 8 cycles.
    for (int k = 0; k < 4; k++) cnt[k] = 0;
    rst = 1'b0; in_valid = 4'b1111; in_data = D; out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      check("onehot", 100 + c, 32'($countones(in_ready)), 32'd1);
      for (int k = 0; k < 4; k++) begin
        if (in_ready[k] && in_valid[k]) cnt[k]++;
      end
      @(posedge clk);
      #1;
    end
`ifndef RV_ARB_FIXED_PRI_EN
    for (int k = 0; k < 4; k++) check("rr_count", 200 + k, 32'(cnt[k]), 32'd2);
`else
    check("fp_count0", 200, 32'(cnt[0]), 32'd8);
    check("fp_count3", 203, 32'(cnt[3]), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
